// File: rtl/branch_alu_ctrl_if.sv
// Decode-stage bundle for the branch/ALU control unit: instruction fields,
// register flags and the three registered control results.
interface branch_alu_ctrl_if;
   logic       flush;
   logic [5:0] opcode;
   logic [9:0] pc;
   logic [9:0] offset;
   logic [3:0] branch_cond;
   logic       za, zb;
   logic       na, nb;
   logic       ca, cb;
   logic [2:0] alu_ctl;
   logic [9:0] branch_target;
   logic       taken;

   // No valid/ready: the unit samples every field on every rising edge and the
   // results are valid exactly one edge later unless squashed by flush or reset.
   modport master (
      output flush, opcode, pc, offset, branch_cond, za, zb, na, nb, ca, cb,
      input  alu_ctl, branch_target, taken
   );

   modport slave (
      input  flush, opcode, pc, offset, branch_cond, za, zb, na, nb, ca, cb,
      output alu_ctl, branch_target, taken
   );
endinterface

// File: rtl/branch_alu_ctrl_unit.sv
// Decode-stage control: ALU op decode, PC-relative branch target and
// branch-taken evaluation, all registered with a single cycle of latency.
module branch_alu_ctrl_unit (
   input  logic              clk,
   input  logic              reset,
   branch_alu_ctrl_if.slave  bus
);

   logic [2:0] alu_next;
   logic [9:0] target_next;
   logic       taken_next;

   always_comb begin
      alu_next = 3'b000;
      unique case (bus.opcode[5:3])
         3'b000:  alu_next = 3'b000;
         3'b001:  alu_next = 3'b001;
         3'b010:  alu_next = 3'b010;
         3'b011:  alu_next = 3'b011;
         3'b100:  alu_next = bus.opcode[0] ? 3'b110 : 3'b101;
         3'b101:  alu_next = 3'b111;
         3'b110:  alu_next = 3'b000;
         default: alu_next = 3'b100;
      endcase
   end

   // Unsigned 10-bit add is identical to pc + signed offset modulo 1024.
   assign target_next = bus.pc + bus.offset;

   always_comb begin
      taken_next = 1'b0;
      case (bus.branch_cond)
         4'b0001: taken_next =  bus.za;
         4'b0010: taken_next = ~bus.za;
         4'b0011: taken_next =  bus.ca;
         4'b0100: taken_next = ~bus.ca;
         4'b0101: taken_next =  bus.na;
         4'b0110: taken_next = ~bus.na;
         4'b0111: taken_next =  bus.zb;
         4'b1000: taken_next = ~bus.zb;
         4'b1001: taken_next =  bus.cb;
         4'b1010: taken_next = ~bus.cb;
         4'b1011: taken_next =  bus.nb;
         4'b1100: taken_next = ~bus.nb;
         default: taken_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.alu_ctl       <= 3'b000;
         bus.branch_target <= 10'd0;
         bus.taken         <= 1'b0;
      end else if (bus.flush) begin
         bus.alu_ctl       <= 3'b000;
         bus.branch_target <= 10'd0;
         bus.taken         <= 1'b0;
      end else begin
         bus.alu_ctl       <= alu_next;
         bus.branch_target <= target_next;
         bus.taken         <= taken_next;
      end
   end

endmodule

// File: tb/tb_branch_alu_ctrl_unit.sv
// Self-checking bench for branch_alu_ctrl_unit: directed corner cases, a full
// branch_cond x flag sweep and randomized traffic against a behavioural model.
module tb_branch_alu_ctrl_unit;

   logic clk;
   logic reset;
   branch_alu_ctrl_if bus();

   branch_alu_ctrl_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [13:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int model_alu(input int op);
      int cls;
      cls = op / 8;
      case (cls)
         0: return 0;
         1: return 1;
         2: return 2;
         3: return 3;
         4: return 5 + (op % 2);
         5: return 7;
         6: return 0;
         default: return 4;
      endcase
   endfunction

   function automatic int model_target(input int pc, input int off);
      int soff, t;
      soff = (off >= 512) ? off - 1024 : off;
      t = pc + soff;
      return ((t % 1024) + 1024) % 1024;
   endfunction

   // flags packed as {za,na,ca,zb,nb,cb}; codes 1..12 test za,ca,na,zb,cb,nb
   // in pairs, odd code = flag set, even code = flag clear.
   function automatic int model_taken(input int bc, input logic [5:0] f);
      int sel[6] = '{5, 3, 4, 2, 0, 1};
      int idx;
      if (bc < 1 || bc > 12) return 0;
      idx = (bc - 1) / 2;
      return (bc % 2 == 1) ? int'(f[sel[idx]]) : int'(!f[sel[idx]]);
   endfunction

   function automatic logic [13:0] model(input int op, input int pc, input int off,
                                         input int bc, input logic [5:0] f, input bit fl);
      logic [2:0] a;
      logic [9:0] t;
      logic       k;
      if (fl) return 14'd0;
      a = 3'(model_alu(op));
      t = 10'(model_target(pc, off));
      k = 1'(model_taken(bc, f));
      return {a, t, k};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_outputs(input string tag, input logic [13:0] e);
      check({tag, ".alu"},    32'(bus.alu_ctl),       32'(e[13:11]));
      check({tag, ".target"}, 32'(bus.branch_target), 32'(e[10:1]));
      check({tag, ".taken"},  32'(bus.taken),         32'(e[0]));
   endtask

   // ---------------- driver ----------------
   // Apply inputs at the falling edge and queue the result the next rising edge
   // must produce.
   task automatic drive(input int op, input int pc, input int off, input int bc,
                        input logic [5:0] f, input bit fl);
      @(negedge clk);
      bus.opcode      = 6'(op);
      bus.pc          = 10'(pc);
      bus.offset      = 10'(off);
      bus.branch_cond = 4'(bc);
      {bus.za, bus.na, bus.ca, bus.zb, bus.nb, bus.cb} = f;
      bus.flush       = fl;
      exp_q.push_back(model(op, pc, off, bc, f, fl));
   endtask

   task automatic step(input string tag);
      logic [13:0] e;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_outputs(tag, e);
   endtask

   task automatic run(input string tag, input int op, input int pc, input int off,
                      input int bc, input logic [5:0] f, input bit fl);
      drive(op, pc, off, bc, f, fl);
      step(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0;
      bus.flush = 1'b0; bus.opcode = 6'h3f; bus.pc = 10'h3ff; bus.offset = 10'h1;
      bus.branch_cond = 4'd2;
      {bus.za, bus.na, bus.ca, bus.zb, bus.nb, bus.cb} = 6'b0;
      #1;
      check_outputs("reset_async", 14'd0);
      @(posedge clk); #1;
      check_outputs("reset_hold", 14'd0);

      // Release reset; first edge loads computed values.
      drive(6'b000000, 5, 3, 1, 6'b100000, 1'b0);
      reset = 1'b1;
      step("first_edge");

      run("shr_wrap",  6'b100001, 0,    1023, 0, 6'b0, 1'b0);
      run("shl",       6'b100000, 100,  20,   0, 6'b0, 1'b0);
      run("pc_wrap",   6'b101110, 1020, 10,   0, 6'b0, 1'b0);
      run("sub",       6'b001111, 10,   1000, 7, 6'b000100, 1'b0);
      run("xor",       6'b111010, 512,  512,  13, 6'b111111, 1'b0);

      // Full taken-table sweep.
      for (int bc = 0; bc < 16; bc++)
         for (int f = 0; f < 64; f++)
            run("sweep", $urandom_range(0, 63), $urandom_range(0, 1023),
                $urandom_range(0, 1023), bc, 6'(f), 1'b0);

      // Flush squashes a taken branch for one edge, then values reappear.
      run("pre_flush", 6'b110000, 300, 40, 1, 6'b100000, 1'b0);
      run("flush",     6'b110000, 300, 40, 1, 6'b100000, 1'b1);
      run("post_flush",6'b110000, 300, 40, 1, 6'b100000, 1'b0);

      // Async reset between edges while outputs are nonzero.
      run("pre_reset", 6'b011000, 77, 9, 2, 6'b000000, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_outputs("mid_reset", 14'd0);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      check_outputs("reset_over_flush", 14'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      @(posedge clk); #1;
      check_outputs("reset_hold2", 14'd0);
      drive(6'b010101, 1, 2, 3, 6'b001000, 1'b0);
      reset = 1'b1;
      step("reset_release");

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         run("random", $urandom_range(0, 63), $urandom_range(0, 1023),
             $urandom_range(0, 1023), $urandom_range(0, 15),
             6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
